// File: rtl/conv2d_engine_pkg.sv
// Shared constants and types for the convolution stage and its neighbours.
package conv2d_engine_pkg;

    localparam int DATA_WIDTH      = 16;
    localparam int IFMAP_SIZE      = 28;
    localparam int KERNEL_SIZE     = 3;
    localparam int FRAC_BITS       = 8;
    localparam int CONV_OFMAP_SIZE = IFMAP_SIZE - KERNEL_SIZE + 1;

    localparam int CONV_COUNTER_SIZE   = $clog2(CONV_OFMAP_SIZE);
    localparam int KERNEL_COUNTER_SIZE = $clog2(KERNEL_SIZE);
    // Sized so a full kernel of extreme products plus shifted bias cannot overflow.
    localparam int CONV_ACC_WIDTH      = 2 * DATA_WIDTH + $clog2(KERNEL_SIZE * KERNEL_SIZE) + 1;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_MAC,
        CONV_WRITE,
        CONV_DONE
    } conv_state_t;

    typedef logic signed [DATA_WIDTH-1:0]     data_t;
    typedef logic signed [CONV_ACC_WIDTH-1:0] acc_t;

endpackage

// File: rtl/conv2d_engine_if.sv
// Map/kernel/bias inputs, ofmap output and start/done handshake of the conv stage.
interface conv2d_engine_if;
    import conv2d_engine_pkg::*;

    logic  en;
    data_t ifmap   [IFMAP_SIZE][IFMAP_SIZE];
    data_t weights [KERNEL_SIZE][KERNEL_SIZE];
    data_t bias;
    data_t ofmap   [CONV_OFMAP_SIZE][CONV_OFMAP_SIZE];
    logic  done_conv;

    modport master (output en, ifmap, weights, bias, input ofmap, done_conv);
    modport slave  (input en, ifmap, weights, bias, output ofmap, done_conv);

endinterface

// File: rtl/conv2d_engine_relu_sat.sv
// Requantizer: ReLU, drop fractional product bits, saturate to the positive data range.
module relu_sat
    import conv2d_engine_pkg::*;
(
    input  acc_t  acc_i,
    output data_t data_o
);

    localparam data_t DATA_MAX = data_t'({1'b0, {(DATA_WIDTH-1){1'b1}}});

    acc_t shifted;

    always_comb begin
        shifted = acc_i >>> FRAC_BITS;
        data_o  = '0;
        if (!acc_i[CONV_ACC_WIDTH-1]) begin
            // Any set bit at or above the data sign position means out of range.
            if (|shifted[CONV_ACC_WIDTH-1:DATA_WIDTH-1]) begin
                data_o = DATA_MAX;
            end else begin
                data_o = shifted[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/conv2d_engine.sv
// Valid-mode single-channel 2-D convolution, one MAC per cycle, bias + ReLU + requant
// per output pixel; done_conv feeds the pool stage's enable.
module conv2d_engine
    import conv2d_engine_pkg::*;
(
    input logic           clk,
    input logic           reset,
    conv2d_engine_if.slave bus
);

    localparam int IDX_W = $clog2(IFMAP_SIZE);
    localparam logic [KERNEL_COUNTER_SIZE-1:0] K_LAST = KERNEL_COUNTER_SIZE'(KERNEL_SIZE - 1);
    localparam logic [CONV_COUNTER_SIZE-1:0]   O_LAST = CONV_COUNTER_SIZE'(CONV_OFMAP_SIZE - 1);

    conv_state_t                    state_q, state_d;
    logic [CONV_COUNTER_SIZE-1:0]   out_row_q, out_row_d, out_col_q, out_col_d;
    logic [KERNEL_COUNTER_SIZE-1:0] k_row_q, k_row_d, k_col_q, k_col_d;
    acc_t                           acc_q, acc_d;
    data_t                          ofmap_q [CONV_OFMAP_SIZE][CONV_OFMAP_SIZE];
    logic                           wr_en;

    logic [IDX_W-1:0]               px_row, px_col;
    data_t                          px, wt;
    logic signed [2*DATA_WIDTH-1:0] prod;
    acc_t                           biased;
    data_t                          requant;

    assign px_row = IDX_W'(out_row_q) + IDX_W'(k_row_q);
    assign px_col = IDX_W'(out_col_q) + IDX_W'(k_col_q);
    assign px     = bus.ifmap[px_row][px_col];
    assign wt     = bus.weights[k_row_q][k_col_q];
    assign prod   = px * wt;
    // Bias shares the data Q format; shifting aligns it with the product scale.
    assign biased = acc_q + (acc_t'(bus.bias) <<< FRAC_BITS);

    relu_sat u_relu_sat (
        .acc_i  (biased),
        .data_o (requant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CONV_IDLE;
            out_row_q <= '0;
            out_col_q <= '0;
            k_row_q   <= '0;
            k_col_q   <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
            k_row_q   <= k_row_d;
            k_col_q   <= k_col_d;
            acc_q     <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < CONV_OFMAP_SIZE; r++) begin
                for (int unsigned c = 0; c < CONV_OFMAP_SIZE; c++) begin
                    ofmap_q[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            ofmap_q[out_row_q][out_col_q] <= requant;
        end
    end

    always_comb begin
        state_d   = state_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        k_row_d   = k_row_q;
        k_col_d   = k_col_q;
        acc_d     = acc_q;
        wr_en     = 1'b0;
        unique case (state_q)
            CONV_IDLE: begin
                if (bus.en) begin
                    state_d   = CONV_MAC;
                    out_row_d = '0;
                    out_col_d = '0;
                    k_row_d   = '0;
                    k_col_d   = '0;
                    acc_d     = '0;
                end
            end
            CONV_MAC: begin
                acc_d = acc_q + acc_t'(prod);
                if (k_col_q == K_LAST) begin
                    k_col_d = '0;
                    if (k_row_q == K_LAST) begin
                        k_row_d = '0;
                        state_d = CONV_WRITE;
                    end else begin
                        k_row_d = k_row_q + 1'b1;
                    end
                end else begin
                    k_col_d = k_col_q + 1'b1;
                end
            end
            CONV_WRITE: begin
                wr_en   = 1'b1;
                acc_d   = '0;
                k_row_d = '0;
                k_col_d = '0;
                if (out_row_q == O_LAST && out_col_q == O_LAST) begin
                    state_d = CONV_DONE;
                end else begin
                    state_d = CONV_MAC;
                    if (out_col_q == O_LAST) begin
                        out_col_d = '0;
                        out_row_d = out_row_q + 1'b1;
                    end else begin
                        out_col_d = out_col_q + 1'b1;
                    end
                end
            end
            CONV_DONE: begin
            end
            default: state_d = CONV_IDLE;
        endcase
    end

    assign bus.ofmap     = ofmap_q;
    assign bus.done_conv = (state_q == CONV_DONE);

endmodule

// File: tb/tb_conv2d_engine.sv
// Scoreboard bench for conv2d_engine: passes push expected maps, a monitor checks on done_conv.
module tb_conv2d_engine;
    import conv2d_engine_pkg::*;

    localparam int OF   = CONV_OFMAP_SIZE;
    localparam int K    = KERNEL_SIZE;
    localparam int N    = IFMAP_SIZE;
    localparam int LAT  = 1 + OF * OF * (K * K + 1);
    localparam int MAXV = (1 << (DATA_WIDTH - 1)) - 1;

    typedef struct {
        string name;
        int    t_en;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    exp_t exp_q[$];
    int   exp_pix[$];
    exp_t cur;
    logic done_prev = 1'b0;

    conv2d_engine_if bus ();

    conv2d_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, longint act, longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endfunction

    // Reference: plain sum of products, then ReLU / divide / clamp.
    function automatic int ref_pixel(int r, int c);
        longint s = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += longint'(bus.ifmap[r+i][c+j]) * longint'(bus.weights[i][j]);
        s += longint'(bus.bias) * (longint'(1) << FRAC_BITS);
        if (s < 0) return 0;
        s = s / (longint'(1) << FRAC_BITS);
        if (s > MAXV) return MAXV;
        return int'(s);
    endfunction

    function automatic int nonzero_count();
        int n = 0;
        for (int r = 0; r < OF; r++)
            for (int c = 0; c < OF; c++)
                if (bus.ofmap[r][c] != 0) n++;
        return n;
    endfunction

    // Monitor: on each rising done_conv, pop one expected pass and compare.
    always @(negedge clk) begin
        if (bus.done_conv === 1'b1 && done_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                cur = exp_q.pop_front();
                check({cur.name, " latency"}, cyc - cur.t_en, LAT);
                for (int r = 0; r < OF; r++)
                    for (int c = 0; c < OF; c++)
                        check($sformatf("%s ofmap[%0d][%0d]", cur.name, r, c),
                              longint'(bus.ofmap[r][c]), exp_pix.pop_front());
            end
        end
        done_prev = bus.done_conv;
    end

    task automatic fill(int iv, int wv, int bv);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                bus.ifmap[r][c] = data_t'(iv);
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                bus.weights[r][c] = data_t'(wv);
        bus.bias = data_t'(bv);
    endtask

    task automatic start_pass(string nm, bit expect_done);
        exp_t e;
        @(negedge clk);
        bus.en = 1'b1;
        if (expect_done) begin
            e.name = nm;
            e.t_en = cyc;
            exp_q.push_back(e);
            for (int r = 0; r < OF; r++)
                for (int c = 0; c < OF; c++)
                    exp_pix.push_back(ref_pixel(r, c));
        end
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    task automatic wait_done(string nm);
        int n = 0;
        while (bus.done_conv !== 1'b1 && n < LAT + 100) begin
            @(negedge clk);
            n++;
        end
        check({nm, " done reached"}, longint'(bus.done_conv === 1'b1), 1);
        if (bus.done_conv !== 1'b1) begin
            exp_q.delete();
            exp_pix.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 1'b0;
        fill(0, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset done_conv", longint'(bus.done_conv), 0);
        check("reset ofmap nonzero", nonzero_count(), 0);

        fill('h0100, 'h0100, 0);
        start_pass("ones", 1'b1);
        wait_done("ones");
        do_reset();

        fill(0, 0, 'h0080);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                bus.ifmap[r][c] = data_t'((r + c) << FRAC_BITS);
        bus.weights[K/2][K/2] = data_t'('h0100);
        start_pass("centre", 1'b1);
        wait_done("centre");
        check("centre corner [0][0]", longint'(bus.ofmap[0][0]), 'h0280);
        check("centre corner [25][25]", longint'(bus.ofmap[OF-1][OF-1]), 'h3480);
        do_reset();

        fill('h0100, -'h0100, 0);
        start_pass("relu", 1'b1);
        wait_done("relu");
        do_reset();

        fill('h7FFF, 'h7FFF, 'h7FFF);
        start_pass("saturate", 1'b1);
        wait_done("saturate");
        do_reset();

        fill('h0100, 'h0100, 0);
        start_pass("aborted", 1'b0);
        repeat (100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort done_conv", longint'(bus.done_conv), 0);
        check("abort ofmap nonzero", nonzero_count(), 0);
        start_pass("after_abort", 1'b1);
        wait_done("after_abort");
        do_reset();

        start_pass("en_pulses", 1'b1);
        repeat (50) @(negedge clk);
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        wait_done("en_pulses");
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold done_conv", longint'(bus.done_conv), 1);
            check("hold ofmap[0][0]", longint'(bus.ofmap[0][0]), 'h0900);
        end
        do_reset();

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                bus.ifmap[r][c] = data_t'(int'($urandom_range(0, 4095)) - 2048);
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                bus.weights[r][c] = data_t'(int'($urandom_range(0, 127)) - 64);
        bus.bias = data_t'(int'($urandom_range(0, 8191)) - 4096);
        start_pass("random_small", 1'b1);
        wait_done("random_small");
        do_reset();

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                bus.ifmap[r][c] = data_t'($urandom_range(0, 65535));
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                bus.weights[r][c] = data_t'($urandom_range(0, 65535));
        bus.bias = data_t'($urandom_range(0, 65535));
        start_pass("random_full", 1'b1);
        wait_done("random_full");

        check("leftover expectations", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
